// File: rtl/vx_wb_arbiter.sv
// Round-robin writeback arbiter for one issue slot. It locks onto a requester until its eop beat,
// drives a registered ready/valid output stage, and counts contention cycles.
module vx_wb_arbiter #(
  parameter  int NUM_REQS = 4,
  parameter  int DATAW    = 64,
  parameter  int CTR_W    = 44,
  localparam int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_eop,
  output logic [IDXW-1:0]           out_idx,
  input  logic                      out_ready,
  output logic [CTR_W-1:0]          perf_conflicts
);

  // state   | meaning
  // ST_ARB  | free: round-robin scan of all requesters starting at rr_ptr
  // ST_LOCK | mid-writeback: only lock_idx may be granted, until its eop beat
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   lock_idx_q, lock_idx_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q;
  logic [DATAW-1:0]  out_data_q;
  logic              out_eop_q;
  logic [IDXW-1:0]   out_idx_q;
  logic [CTR_W-1:0]  perf_q;

  logic              load;
  logic              fire;
  logic              grant_any;
  logic [IDXW-1:0]   grant;
  logic              conflict;

  assign load = !out_valid_q || out_ready;
  assign fire = load && grant_any;

  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign conflict = |(req_valid & (req_valid - NUM_REQS'(1)));

  // Reverse scan so the lowest offset from rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    if (state_q == ST_LOCK) begin
      grant     = lock_idx_q;
      grant_any = req_valid[lock_idx_q];
    end else begin
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (req_valid[(int'(rr_ptr_q) + i) % NUM_REQS]) begin
          grant     = IDXW'((int'(rr_ptr_q) + i) % NUM_REQS);
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && fire) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (fire) begin
      if (req_eop[grant]) begin
        state_d  = ST_ARB;
        rr_ptr_d = (grant == IDXW'(NUM_REQS - 1)) ? '0 : grant + IDXW'(1);
      end else begin
        state_d    = ST_LOCK;
        lock_idx_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARB;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Payload fields hold when a drained slot is not refilled; only valid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
      out_idx_q   <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= req_data[grant*DATAW +: DATAW];
      out_eop_q   <= req_eop[grant];
      out_idx_q   <= grant;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (conflict) begin
      perf_q <= perf_q + CTR_W'(1);
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_eop        = out_eop_q;
  assign out_idx        = out_idx_q;
  assign perf_conflicts = perf_q;

endmodule
